// File: rtl/led_pkg.sv
// Shared types and constants for the multiplexed seven-segment display driver.
// Segment vectors are ordered {a,b,c,d,e,f,g} (bit 6 = a, bit 0 = g), active-high.
package led_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b0000000;

    // Hex glyphs 0..F in {a..g} order.
    localparam seg7_t SEG_HEX [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/led_hex7.sv
// Combinational hex nibble to seven-segment glyph decoder.
// Ports:
//   nibble_i  4-bit hex value
//   seg_o     glyph {a..g}, active-high
module led_hex7
    import led_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg7_t      seg_o
);

    assign seg_o = SEG_HEX[nibble_i];

endmodule

// File: rtl/led_scan.sv
// Time-multiplexed driver for DIGITS common-cathode seven-segment digits.
// A prescaler produces one tick every DIV clocks; each tick advances the scanned digit.
// Display values live in a shadow register loaded by a one-cycle strobe. Outputs are
// registered from next-state index/shadow, so pins follow tick/load by one clock.
// Optional build macro: LED_DP_EN adds per-digit decimal point input dp and output seg_dp.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   data     4*DIGITS hex nibbles, nibble i shown on digit i (digit 0 least significant)
//   load     strobe, captures data (and dp) into the shadow register
//   blank    high = all digits dark, scanning continues underneath
//   lzs      high = leading-zero suppression (digit 0 never suppressed)
//   dp       (LED_DP_EN only) per-digit decimal point, captured on load
//   seg_dp   (LED_DP_EN only) decimal point of the scanned digit, registered
//   seg      {a..g} active-high, registered
//   led_sel  active-low one-hot digit select, registered
module led_scan
    import led_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  load,
    input  logic                  blank,
    input  logic                  lzs,
`ifdef LED_DP_EN
    input  logic [DIGITS-1:0]     dp,
    output logic                  seg_dp,
`endif
    output seg7_t                 seg,
    output logic [DIGITS-1:0]     led_sel
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    seg7_t                 seg_q, seg_d;
    logic [DIGITS-1:0]     led_sel_q, led_sel_d;
    logic                  tick;
    logic [3:0]            nib_sel;
    logic                  sup;
    logic [DIGITS:0]       zero_up;
    seg7_t                 hex_seg;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        shadow_d = load ? data : shadow_q;
    end

    // zero_up[i]: nibbles i..DIGITS-1 of the next shadow value are all zero.
    always_comb begin
        zero_up         = '0;
        zero_up[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_up[i] = zero_up[i+1] & (shadow_d[4*i +: 4] == 4'h0);
        end
    end

    // Select the nibble for the next scanned digit and decide suppression.
    always_comb begin
        nib_sel = 4'h0;
        sup     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                nib_sel = shadow_d[4*i +: 4];
                sup     = lzs && (i != 0) && zero_up[i];
            end
        end
    end

    led_hex7 u_hex7 (
        .nibble_i (nib_sel),
        .seg_o    (hex_seg)
    );

    // A suppressed digit keeps its select so scan timing is unchanged.
    always_comb begin
        seg_d     = (blank || sup) ? SEG_BLANK : hex_seg;
        led_sel_d = '1;
        if (!blank) begin
            for (int i = 0; i < DIGITS; i++) begin
                led_sel_d[i] = (idx_d != IW'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            seg_q     <= SEG_BLANK;
            led_sel_q <= '1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            seg_q     <= seg_d;
            led_sel_q <= led_sel_d;
        end
    end

    assign seg     = seg_q;
    assign led_sel = led_sel_q;

`ifdef LED_DP_EN
    logic [DIGITS-1:0] dp_q, dp_d;
    logic              seg_dp_q, seg_dp_d;

    always_comb begin
        dp_d     = load ? dp : dp_q;
        seg_dp_d = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                seg_dp_d = dp_d[i];
            end
        end
        if (blank) begin
            seg_dp_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_q     <= '0;
            seg_dp_q <= 1'b0;
        end else begin
            dp_q     <= dp_d;
            seg_dp_q <= seg_dp_d;
        end
    end

    assign seg_dp = seg_dp_q;
`endif

endmodule

// File: tb/tb_led_scan.sv
// Directed bench for led_scan: a 4-digit/DIV=4 instance and a 1-digit/DIV=1 instance.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_led_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic        load, blank, lzs;
    logic [6:0]  seg;
    logic [3:0]  led_sel;

    logic [3:0]  data1;
    logic        load1, blank1, lzs1;
    logic [6:0]  seg1;
    logic [0:0]  led_sel1;

`ifdef LED_DP_EN
    logic [3:0]  dp;
    logic        seg_dp;
    logic [0:0]  dp1;
    logic        seg_dp1;
`endif

    int n_total = 0;
    int n_bad   = 0;

    led_scan #(.DIGITS(4), .DIV(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .load    (load),
        .blank   (blank),
        .lzs     (lzs),
`ifdef LED_DP_EN
        .dp      (dp),
        .seg_dp  (seg_dp),
`endif
        .seg     (seg),
        .led_sel (led_sel)
    );

    led_scan #(.DIGITS(1), .DIV(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data1),
        .load    (load1),
        .blank   (blank1),
        .lzs     (lzs1),
`ifdef LED_DP_EN
        .dp      (dp1),
        .seg_dp  (seg_dp1),
`endif
        .seg     (seg1),
        .led_sel (led_sel1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] sel, input logic [6:0] sg);
        check_eq({tag, "_sel"}, 32'(led_sel), 32'(sel));
        check_eq({tag, "_seg"}, 32'(seg), 32'(sg));
    endtask

    initial begin
        rst_n  = 1'b0;
        load   = 1'b1;
        data   = 16'h1234;
        blank  = 1'b0;
        lzs    = 1'b0;
        data1  = 4'h0;
        load1  = 1'b0;
        blank1 = 1'b0;
        lzs1   = 1'b0;
`ifdef LED_DP_EN
        dp     = 4'h0;
        dp1    = 1'b0;
`endif

        // Reset held while load is driven: outputs dark, shadow must not capture.
        clk_n(1);
        chk4("rst_a", 4'b1111, 7'h00);
        clk_n(2);
        chk4("rst_b", 4'b1111, 7'h00);
        load  = 1'b0;
        rst_n = 1'b1;

        clk_n(1);                       // E1: digit 0 of zero shadow
        chk4("rel_e1", 4'b1110, 7'h7E);
        clk_n(3);                       // E4: first tick
        chk4("first_tick", 4'b1101, 7'h7E);

        // Scan of 1234 starting at digit 1.
        load = 1'b1; data = 16'h1234;
        clk_n(1);                       // E5
        chk4("scan_d1", 4'b1101, 7'h79);
        load = 1'b0;
        clk_n(2);                       // E7: no step yet
        chk4("scan_hold", 4'b1101, 7'h79);
        clk_n(1);                       // E8
        chk4("scan_d2", 4'b1011, 7'h6D);
        clk_n(4);                       // E12
        chk4("scan_d3", 4'b0111, 7'h30);
        clk_n(4);                       // E16
        chk4("scan_d0", 4'b1110, 7'h33);
        clk_n(4);                       // E20
        chk4("scan_wrap", 4'b1101, 7'h79);

        // Leading-zero suppression with 0050.
        lzs = 1'b1; load = 1'b1; data = 16'h0050;
        clk_n(1);                       // E21
        chk4("lzs_d1", 4'b1101, 7'h5B);
        load = 1'b0;
        clk_n(3);                       // E24
        chk4("lzs_d2", 4'b1011, 7'h00);
        clk_n(4);                       // E28
        chk4("lzs_d3", 4'b0111, 7'h00);
        clk_n(4);                       // E32
        chk4("lzs_d0", 4'b1110, 7'h7E);
        clk_n(4);                       // E36
        chk4("lzs_d1b", 4'b1101, 7'h5B);

        // All zero: only digit 0 lit.
        load = 1'b1; data = 16'h0000;
        clk_n(1);                       // E37
        chk4("lzs0_d1", 4'b1101, 7'h00);
        load = 1'b0;
        clk_n(11);                      // E48
        chk4("lzs0_d0", 4'b1110, 7'h7E);

        // 1020 under lzs: inner zeros stay visible.
        load = 1'b1; data = 16'h1020;
        clk_n(1);                       // E49
        chk4("inz_d0", 4'b1110, 7'h7E);
        load = 1'b0;
        clk_n(3);                       // E52
        chk4("inz_d1", 4'b1101, 7'h6D);

        // Blank mid-scan, idx keeps running underneath.
        clk_n(1);                       // E53
        blank = 1'b1;
        clk_n(1);                       // E54
        chk4("blank_a", 4'b1111, 7'h00);
        clk_n(6);                       // E60
        chk4("blank_b", 4'b1111, 7'h00);
        clk_n(1);                       // E61
        blank = 1'b0;
        clk_n(1);                       // E62: resumes at digit 3
        chk4("unblank", 4'b0111, 7'h30);
        clk_n(10);                      // E72
        chk4("inz_d2", 4'b1011, 7'h7E);

        // Load coinciding with the tick into digit 1.
        clk_n(11);                      // E83: cnt = DIV-1
        chk4("pre_lt", 4'b1110, 7'h7E);
        load = 1'b1; data = 16'hABCD; lzs = 1'b0;
        clk_n(1);                       // E84
        chk4("load_tick", 4'b1101, 7'h4E);
        load = 1'b0;
        clk_n(4);                       // E88
        chk4("after_lt", 4'b1011, 7'h1F);

        // Asynchronous reset mid-scan.
        rst_n = 1'b0;
        #1;
        chk4("arst_now", 4'b1111, 7'h00);
        clk_n(1);
        chk4("arst_hold", 4'b1111, 7'h00);
        rst_n = 1'b1;
        clk_n(1);                       // R1
        chk4("arst_r1", 4'b1110, 7'h7E);
        clk_n(2);                       // R3
        chk4("arst_r3", 4'b1110, 7'h7E);
        clk_n(1);                       // R4: first tick DIV cycles after release
        chk4("arst_r4", 4'b1101, 7'h7E);

        // Single digit, DIV=1.
        load1 = 1'b1; data1 = 4'hA;
`ifdef LED_DP_EN
        dp1 = 1'b1;
`endif
        clk_n(1);
        check_eq("d1_sel", 32'(led_sel1), 32'h0);
        check_eq("d1_segA", 32'(seg1), 32'h77);
`ifdef LED_DP_EN
        check_eq("d1_dp", 32'(seg_dp1), 32'h1);
`endif
        load1 = 1'b0; data1 = 4'h5;
        clk_n(1);
        check_eq("d1_hold", 32'(seg1), 32'h77);
        load1 = 1'b1;
        clk_n(1);
        check_eq("d1_seg5", 32'(seg1), 32'h5B);
        data1 = 4'h0; lzs1 = 1'b1;
        clk_n(1);
        check_eq("d1_lzs0", 32'(seg1), 32'h7E);
        load1 = 1'b0;
        blank1 = 1'b1;
        clk_n(1);
        check_eq("d1_blk_sel", 32'(led_sel1), 32'h1);
        check_eq("d1_blk_seg", 32'(seg1), 32'h00);
`ifdef LED_DP_EN
        check_eq("d1_blk_dp", 32'(seg_dp1), 32'h0);
`endif
        blank1 = 1'b0;
        clk_n(1);
        check_eq("d1_unblk", 32'(led_sel1), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
